// File: rtl/weight_acc_sched.sv
// weight_acc_sched: routes a serial weight stream into NUM_COLS column lanes, DEPTH words each,
// then drains all lanes with a one-cycle diagonal skew; WEIGHT_ACC_SCHED_REPLAY_EN keeps the load drainable.
module weight_acc_sched #(
    parameter int NUM_COLS = 2,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_load,
    input  logic                       start_drain,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [15:0]         s_data,
    output logic signed [15:0]         lane_data_out,
    output logic [NUM_COLS-1:0]        lane_valid_data_out,
    output logic [NUM_COLS-1:0]        lane_valid_out,
    output logic                       busy,
    output logic                       loaded,
    output logic                       done,
    output logic                       err
);
    localparam int DLEN = DEPTH + NUM_COLS - 1;
    localparam int CW   = $clog2(NUM_COLS + 1);
    localparam int SW   = $clog2(DEPTH + 1);
    localparam int DW   = $clog2(DLEN + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, LOADED} state_t;

    state_t              state;
    logic [CW-1:0]       col;
    logic [SW-1:0]       sub;
    logic [DW-1:0]       dcnt;
    logic [DW-1:0]       nt;
    logic [NUM_COLS-1:0] mask;
    logic                sub_last;
    logic                last;

    // dcnt holds the next skew step so the strobes can be registered one cycle ahead
    always_comb begin
        nt   = (state == DRAIN) ? dcnt : '0;
        mask = '0;
        for (int c = 0; c < NUM_COLS; c++)
            mask[c] = int'(nt) >= c && int'(nt) < c + DEPTH;
    end

    assign sub_last = sub == SW'(DEPTH - 1);
    assign last     = sub_last && col == CW'(NUM_COLS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            col                 <= '0;
            sub                 <= '0;
            dcnt                <= '0;
            s_ready             <= 1'b0;
            lane_data_out       <= '0;
            lane_valid_data_out <= '0;
            lane_valid_out      <= '0;
            busy                <= 1'b0;
            loaded              <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
        end else begin
            done                <= 1'b0;
            err                 <= 1'b0;
            lane_valid_data_out <= '0;
            case (state)
                IDLE, LOADED: begin
                    if (start_load) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        loaded  <= 1'b0;
                        col     <= '0;
                        sub     <= '0;
                    end else if (start_drain && loaded) begin
                        state          <= DRAIN;
                        busy           <= 1'b1;
                        dcnt           <= DW'(1);
                        lane_valid_out <= mask;
                    end else if (start_drain) begin
                        err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        lane_data_out       <= s_data;
                        lane_valid_data_out <= NUM_COLS'(1) << col;
                        sub                 <= sub_last ? '0 : sub + SW'(1);
                        col                 <= col + CW'(sub_last);
                        if (last) begin
                            state   <= LOADED;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            loaded  <= 1'b1;
                            done    <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt == DW'(DLEN)) begin
                        lane_valid_out <= '0;
                        done           <= 1'b1;
                        busy           <= 1'b0;
`ifdef WEIGHT_ACC_SCHED_REPLAY_EN
                        state          <= LOADED;
`else
                        state          <= IDLE;
                        loaded         <= 1'b0;
`endif
                    end else begin
                        lane_valid_out <= mask;
                        dcnt           <= dcnt + DW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weight_acc_sched.sv
// tb_weight_acc_sched: directed checks of load routing, stalls, drain skew, illegal starts and replay.
module tb_weight_acc_sched;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start_load = 1'b0;
    logic               start_drain = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [15:0] s_data = '0;
    logic signed [15:0] lane_data_out;
    logic [1:0]         lane_valid_data_out;
    logic [1:0]         lane_valid_out;
    logic               busy;
    logic               loaded;
    logic               done;
    logic               err;

    int n_chk = 0;
    int n_fail = 0;
    int strobes;
    int dones;

    weight_acc_sched #(.NUM_COLS(2), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_drain(start_drain),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .lane_data_out(lane_data_out),
        .lane_valid_data_out(lane_valid_data_out), .lane_valid_out(lane_valid_out),
        .busy(busy), .loaded(loaded), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " s_ready"}, 32'(s_ready), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " loaded"}, 32'(loaded), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " data"}, 32'(lane_data_out), 0);
        chk({tag, " wstrb"}, 32'(lane_valid_data_out), 0);
        chk({tag, " rstrb"}, 32'(lane_valid_out), 0);
    endtask

    logic [1:0] load_strb [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [1:0] drain_pat [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};
    logic       drain_busy[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       drain_done[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        tick();
        tick();
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // abort a load after three words with an asynchronous reset
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        chk("load entry s_ready", 32'(s_ready), 1);
        chk("load entry busy", 32'(busy), 1);
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_data = 16'(k + 1);
            tick();
        end
        chk("partial strobe", 32'(lane_valid_data_out), 32'b01);
        chk("partial data", 32'(lane_data_out), 3);
        #2 rst_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk_idle_outputs("async reset");
        rst_n = 1'b1;
        tick();

        // drain with nothing loaded
        start_drain = 1'b1;
        tick();
        start_drain = 1'b0;
        chk("illegal drain err", 32'(err), 1);
        chk("illegal drain busy", 32'(busy), 0);
        tick();
        chk("err one cycle", 32'(err), 0);

        // both starts together: load wins; drain during LOAD ignored
        start_load = 1'b1;
        start_drain = 1'b1;
        tick();
        start_load = 1'b0;
        chk("both starts busy", 32'(busy), 1);
        chk("both starts s_ready", 32'(s_ready), 1);
        chk("both starts err", 32'(err), 0);
        tick();
        start_drain = 1'b0;
        chk("drain in LOAD err", 32'(err), 0);
        chk("drain in LOAD busy", 32'(busy), 1);
        chk("drain in LOAD rstrb", 32'(lane_valid_out), 0);

        // contiguous stream 10..17
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = 16'(10 + k);
            tick();
            chk($sformatf("load data %0d", k), 32'(lane_data_out), 32'(10 + k));
            chk($sformatf("load strobe %0d", k), 32'(lane_valid_data_out), 32'(load_strb[k]));
            chk($sformatf("load done %0d", k), 32'(done), 32'(k == 7));
            chk($sformatf("load loaded %0d", k), 32'(loaded), 32'(k == 7));
        end
        chk("load end s_ready", 32'(s_ready), 0);
        chk("load end busy", 32'(busy), 0);
        s_data = 16'sd99;
        tick();
        s_valid = 1'b0;
        chk("word outside LOAD strobe", 32'(lane_valid_data_out), 0);
        chk("word outside LOAD data", 32'(lane_data_out), 17);
        chk("done one cycle", 32'(done), 0);
        chk("loaded held", 32'(loaded), 1);

        // drain skew
        start_drain = 1'b1;
        tick();
        start_drain = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("drain1 rstrb e+%0d", i + 1), 32'(lane_valid_out), 32'(drain_pat[i]));
            chk($sformatf("drain1 busy e+%0d", i + 1), 32'(busy), 32'(drain_busy[i]));
            chk($sformatf("drain1 done e+%0d", i + 1), 32'(done), 32'(drain_done[i]));
            if (i < 5) tick();
        end
        tick();
`ifdef WEIGHT_ACC_SCHED_REPLAY_EN
        chk("after drain loaded", 32'(loaded), 1);
`else
        chk("after drain loaded", 32'(loaded), 0);
`endif

        // second drain without reload
        start_drain = 1'b1;
        tick();
        start_drain = 1'b0;
`ifdef WEIGHT_ACC_SCHED_REPLAY_EN
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("replay rstrb e+%0d", i + 1), 32'(lane_valid_out), 32'(drain_pat[i]));
            chk($sformatf("replay done e+%0d", i + 1), 32'(done), 32'(drain_done[i]));
            if (i < 5) tick();
        end
`else
        chk("replay err", 32'(err), 1);
        chk("replay busy", 32'(busy), 0);
        chk("replay rstrb", 32'(lane_valid_out), 0);
`endif
        tick();

        // load with s_valid toggling
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        strobes = 0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            s_valid = (i % 2) == 0;
            s_data = 16'(100 + i);
            tick();
            strobes += 32'($countones(lane_valid_data_out));
            dones += 32'(done);
            chk($sformatf("stall strobe %0d", i), 32'(lane_valid_data_out),
                (i % 2 == 0) ? 32'(load_strb[i / 2]) : 0);
            chk($sformatf("stall data %0d", i), 32'(lane_data_out),
                32'(100 + i - (i % 2)));
        end
        s_valid = 1'b0;
        chk("stall strobe total", 32'(strobes), 8);
        chk("stall done total", 32'(dones), 1);
        chk("stall loaded", 32'(loaded), 1);
        chk("stall s_ready", 32'(s_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
